mips_run_controller: RTL and testbench

Synthesisable run controller that sequences the MIPS core through reset and a controlled number of enabled clock cycles. It generalises the fixed nine-clock simulation drive into a parametrised block with free-run, N-cycle burst and single-step modes, halt support and a cycle counter. It sits between the top level and `mips_core`, driving the core's clock-enable and reset, so benches and board wrappers control execution without hand-toggled clocks.

---
 rtl/mips_run_controller_if.sv | 23 ++
 rtl/mips_run_controller.sv | 75 +++++++
 tb/tb_mips_run_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_run_controller_if.sv
// mips_run_controller_if: control/status bundle between a host and the run controller
interface mips_run_controller_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       mode;
  logic             start;
  logic             step;
  logic             halt;
  logic [CNT_W-1:0] cycles;
  logic             core_en;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    output mode, start, step, halt, cycles,
    input  core_en, core_reset, busy, done, cycle_count
  );
  modport slave (
    input  mode, start, step, halt, cycles,
    output core_en, core_reset, busy, done, cycle_count
  );
endinterface

// File: rtl/mips_run_controller.sv
// mips_run_controller: sequences core reset and enabled cycles in free-run, burst or single-step mode
module mips_run_controller #(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_CYCLES = 9,
  parameter int RST_CYCLES     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mips_run_controller_if.slave ctl
);
  typedef enum logic [2:0] {IDLE, CORE_RST, RUN, STEP_WAIT, STEP_PULSE, DONE} state_t;
  localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] target_q, target_d, count_q, count_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             step_q, core_en_q, core_reset_q, busy_q, done_q, launch;
  // next state, latched run parameters and cycle counter
  always_comb begin
    launch   = ctl.start && ctl.mode != 2'b11;
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    rcnt_d   = rcnt_q;
    count_d  = core_en_q ? count_q + 1'b1 : count_q;
    case (state_q)
      IDLE, DONE: if (launch) begin
        state_d  = CORE_RST;
        mode_d   = ctl.mode;
        target_d = ctl.cycles == '0 ? CNT_W'(DEFAULT_CYCLES) : ctl.cycles;
        count_d  = '0;
        rcnt_d   = '0;
      end
      CORE_RST: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = mode_q == 2'b10 ? STEP_WAIT : RUN;
      end
      RUN: if (ctl.halt || (mode_q == 2'b01 && count_q + 1'b1 == target_q)) state_d = DONE;
      STEP_WAIT: state_d = ctl.halt ? DONE : (ctl.step && !step_q) ? STEP_PULSE : STEP_WAIT;
      STEP_PULSE: state_d = STEP_WAIT;
      default: state_d = IDLE;
    endcase
  end
  // state register; outputs are decoded from the next state so they move with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mode_q       <= 2'b00;
      target_q     <= '0;
      count_q      <= '0;
      rcnt_q       <= '0;
      step_q       <= 1'b0;
      core_en_q    <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      target_q     <= target_d;
      count_q      <= count_d;
      rcnt_q       <= rcnt_d;
      step_q       <= ctl.step;
      core_en_q    <= state_d == RUN || state_d == STEP_PULSE;
      core_reset_q <= state_d == IDLE || state_d == CORE_RST;
      busy_q       <= !(state_d == IDLE || state_d == DONE);
      done_q       <= state_d == DONE;
    end
  end
  assign ctl.core_en     = core_en_q;
  assign ctl.core_reset  = core_reset_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;
  assign ctl.cycle_count = count_q;
endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller: directed scenario bench for the run controller (4-bit counter build)
module tb_mips_run_controller;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  mips_run_controller_if #(.CNT_W(CNT_W)) ctl ();
  mips_run_controller #(.CNT_W(CNT_W), .DEFAULT_CYCLES(9), .RST_CYCLES(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ctl  (ctl)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    ctl.mode = 2'b00; ctl.start = 1'b0; ctl.step = 1'b0; ctl.halt = 1'b0; ctl.cycles = '0;
    tick();
    tick();
    n_checks++;
    if ({ctl.core_reset, ctl.core_en, ctl.busy, ctl.done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 1000", {ctl.core_reset, ctl.core_en, ctl.busy, ctl.done});
    end
    n_checks++;
    if (ctl.cycle_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", ctl.cycle_count);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({ctl.core_reset, ctl.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_flags got %b want 10", {ctl.core_reset, ctl.busy});
    end
  endtask
  task automatic burst_run(input string nm, input logic [3:0] cyc, input int exp);
    int rn, en, k;
    ctl.mode = 2'b01; ctl.cycles = cyc; ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0; ctl.mode = 2'b00; ctl.cycles = 4'd7;
    n_checks++;
    if ({ctl.busy, ctl.core_reset, ctl.core_en} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s_start got %b want 110", nm, {ctl.busy, ctl.core_reset, ctl.core_en});
    end
    rn = ctl.core_reset; en = 0; k = 0;
    while (!ctl.done && k < 40) begin
      ctl.start = (k == 3);
      tick();
      k++;
      rn += int'(ctl.core_reset);
      en += int'(ctl.core_en);
    end
    ctl.start = 1'b0;
    n_checks++;
    if (rn !== 2) begin
      n_fail++;
      $display("FAIL %s_rst_len got %0d want 2", nm, rn);
    end
    n_checks++;
    if (en !== exp) begin
      n_fail++;
      $display("FAIL %s_en_len got %0d want %0d", nm, en, exp);
    end
    n_checks++;
    if (k !== 2 + exp) begin
      n_fail++;
      $display("FAIL %s_done_edge got E%0d want E%0d", nm, k, 2 + exp);
    end
    n_checks++;
    if ({ctl.done, ctl.busy, ctl.core_en, ctl.core_reset, ctl.cycle_count} !== {4'b1000, 4'(exp)}) begin
      n_fail++;
      $display("FAIL %s_final got d%b b%b e%b r%b cnt%0d want d1 b0 e0 r0 cnt%0d", nm,
               ctl.done, ctl.busy, ctl.core_en, ctl.core_reset, ctl.cycle_count, exp);
    end
  endtask
  task automatic test_default_burst();
    burst_run("default", 4'd0, 9);
  endtask
  task automatic test_back_to_back();
    burst_run("burst1", 4'd1, 1);
    burst_run("burst3", 4'd3, 3);
  endtask
  task automatic test_free_run();
    ctl.mode = 2'b00; ctl.cycles = 4'd2; ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    for (int i = 1; i <= 21; i++) tick();
    n_checks++;
    if ({ctl.core_en, ctl.cycle_count} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL free_wrap got en%b cnt%0d want en1 cnt3", ctl.core_en, ctl.cycle_count);
    end
    ctl.halt = 1'b1;
    tick();
    ctl.halt = 1'b0;
    n_checks++;
    if ({ctl.done, ctl.core_en, ctl.busy, ctl.cycle_count} !== {3'b100, 4'd4}) begin
      n_fail++;
      $display("FAIL free_halt got d%b e%b b%b cnt%0d want d1 e0 b0 cnt4",
               ctl.done, ctl.core_en, ctl.busy, ctl.cycle_count);
    end
    tick();
    n_checks++;
    if ({ctl.done, ctl.core_en, ctl.cycle_count} !== {2'b10, 4'd4}) begin
      n_fail++;
      $display("FAIL free_after got d%b e%b cnt%0d want d1 e0 cnt4", ctl.done, ctl.core_en, ctl.cycle_count);
    end
  endtask
  task automatic test_single_step();
    int en;
    ctl.mode = 2'b10; ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ctl.busy, ctl.core_en, ctl.core_reset} !== 3'b100) begin
      n_fail++;
      $display("FAIL step_wait got %b want 100", {ctl.busy, ctl.core_en, ctl.core_reset});
    end
    en = 0;
    for (int p = 0; p < 3; p++) begin
      ctl.step = 1'b1;
      tick();
      n_checks++;
      if (ctl.core_en !== 1'b1) begin
        n_fail++;
        $display("FAIL step_pulse%0d got %b want 1", p, ctl.core_en);
      end
      en += int'(ctl.core_en);
      ctl.step = 1'b0;
      tick();
      en += int'(ctl.core_en);
      tick();
      en += int'(ctl.core_en);
    end
    ctl.step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      en += int'(ctl.core_en);
    end
    ctl.step = 1'b0;
    tick();
    en += int'(ctl.core_en);
    ctl.halt = 1'b1;
    tick();
    ctl.halt = 1'b0;
    n_checks++;
    if (en !== 4) begin
      n_fail++;
      $display("FAIL step_pulses got %0d want 4", en);
    end
    n_checks++;
    if ({ctl.done, ctl.busy, ctl.cycle_count} !== {2'b10, 4'd4}) begin
      n_fail++;
      $display("FAIL step_done got d%b b%b cnt%0d want d1 b0 cnt4", ctl.done, ctl.busy, ctl.cycle_count);
    end
  endtask
  task automatic test_step_halt_and_reserved();
    ctl.mode = 2'b10; ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    tick();
    tick();
    ctl.step = 1'b1; ctl.halt = 1'b1;
    tick();
    ctl.step = 1'b0; ctl.halt = 1'b0;
    n_checks++;
    if ({ctl.done, ctl.core_en, ctl.cycle_count} !== {2'b10, 4'd0}) begin
      n_fail++;
      $display("FAIL step_halt got d%b e%b cnt%0d want d1 e0 cnt0", ctl.done, ctl.core_en, ctl.cycle_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ctl.mode = 2'b11; ctl.start = 1'b1;
    tick();
    tick();
    ctl.start = 1'b0;
    n_checks++;
    if ({ctl.busy, ctl.core_reset, ctl.done, ctl.core_en} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reserved_mode got %b want 0100", {ctl.busy, ctl.core_reset, ctl.done, ctl.core_en});
    end
  endtask
  task automatic test_async_reset();
    int k;
    ctl.mode = 2'b01; ctl.cycles = 4'd0; ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    k = 0;
    while (ctl.cycle_count !== 4'd5 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (ctl.core_en !== 1'b1 || k !== 7) begin
      n_fail++;
      $display("FAIL async_setup got en%b at E%0d want en1 at E7", ctl.core_en, k);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ctl.core_reset, ctl.core_en, ctl.busy, ctl.done, ctl.cycle_count} !== {4'b1000, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset got r%b e%b b%b d%b cnt%0d want r1 e0 b0 d0 cnt0",
               ctl.core_reset, ctl.core_en, ctl.busy, ctl.done, ctl.cycle_count);
    end
    tick();
    rst = 1'b0;
    tick();
    burst_run("rerun", 4'd0, 9);
  endtask
  initial begin
    test_reset();
    test_default_burst();
    test_back_to_back();
    test_free_run();
    test_single_step();
    test_step_halt_and_reserved();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
